// File: rtl/word_deserializer_8_if.sv
// rtl/word_deserializer_8_if.sv - word stream in, 8-word bundle out
interface word_deserializer_8_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [2:0]       fill_cnt;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, a, b, c, d, e, f, g, h, fill_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, a, b, c, d, e, f, g, h, fill_cnt
    );
endinterface

// File: rtl/word_deserializer_8.sv
// rtl/word_deserializer_8.sv - collects 8 accepted words into one parallel bundle
module word_deserializer_8 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    word_deserializer_8_if.slave bus
);
    logic [WIDTH-1:0] slot_q [8];
    logic [WIDTH-1:0] slot_d [8];
    logic [2:0]       fill_q, fill_d;
    logic             valid_q, valid_d;
    logic             ready;
    logic             accept;
    logic             fire;

    assign ready  = ~valid_q | bus.out_ready;
    assign accept = bus.in_valid & ready;
    assign fire   = valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) slot_q[i] <= '0;
        end else begin
            fill_q  <= fill_d;
            valid_q <= valid_d;
            for (int i = 0; i < 8; i++) slot_q[i] <= slot_d[i];
        end
    end

    // In FULL fill_q is 0, so a fire+accept lands the new word in slot a.
    always_comb begin
        slot_d  = slot_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        if (bus.flush) begin
            fill_d  = '0;
            valid_d = 1'b0;
        end else begin
            if (fire) valid_d = 1'b0;
            if (accept) begin
                slot_d[fill_q] = bus.in_data;
                fill_d         = fill_q + 3'd1;
                if (fill_q == 3'd7) valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready  = ready;
        bus.out_valid = valid_q;
        bus.fill_cnt  = fill_q;
        bus.a         = slot_q[0];
        bus.b         = slot_q[1];
        bus.c         = slot_q[2];
        bus.d         = slot_q[3];
        bus.e         = slot_q[4];
        bus.f         = slot_q[5];
        bus.g         = slot_q[6];
        bus.h         = slot_q[7];
    end
endmodule

// File: tb/tb_word_deserializer_8.sv
// tb/tb_word_deserializer_8.sv - randomized scoreboard bench for word_deserializer_8
module tb_word_deserializer_8;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_fired = 0;

    always #5 clk = ~clk;

    word_deserializer_8_if #(.WIDTH(16)) bus ();
    word_deserializer_8 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] m_part[$];
    logic [15:0] m_bundle [8];
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] slot_out(input int i);
        case (i)
            0: return bus.a;
            1: return bus.b;
            2: return bus.c;
            3: return bus.d;
            4: return bus.e;
            5: return bus.f;
            6: return bus.g;
            default: return bus.h;
        endcase
    endfunction

    task automatic model_reset();
        m_part.delete();
        m_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_bundle[i] = '0;
    endtask

    task automatic compare_outputs();
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check("fill_cnt", {29'd0, bus.fill_cnt}, m_part.size());
        if (m_valid) begin
            for (int i = 0; i < 8; i++) check($sformatf("bundle[%0d]", i), {16'd0, slot_out(i)}, {16'd0, m_bundle[i]});
        end else begin
            for (int i = 0; i < m_part.size(); i++) check($sformatf("partial[%0d]", i), {16'd0, slot_out(i)}, {16'd0, m_part[i]});
        end
    endtask

    // One clock: check ready at the negedge, advance the model at the edge, check outputs after it.
    task automatic cycle();
        logic acc, fire, fl;
        logic [15:0] dw;
        @(negedge clk);
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
        acc  = bus.in_valid && (!m_valid || bus.out_ready);
        fire = m_valid && bus.out_ready;
        dw   = bus.in_data;
        fl   = bus.flush;
        @(posedge clk);
        #1;
        if (fire) n_fired++;
        if (fl) begin
            m_part.delete();
            m_valid = 1'b0;
        end else begin
            if (fire) m_valid = 1'b0;
            if (acc) begin
                m_part.push_back(dw);
                if (m_part.size() == 8) begin
                    for (int i = 0; i < 8; i++) m_bundle[i] = m_part[i];
                    m_part.delete();
                    m_valid = 1'b1;
                end
            end
        end
        compare_outputs();
    endtask

    task automatic drive(input logic v, input logic [15:0] dw, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_data   = dw;
        bus.out_ready = ordy;
        bus.flush     = fl;
        cycle();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        model_reset();
        #3;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_fill_cnt", {29'd0, bus.fill_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_slot[%0d]", i), {16'd0, slot_out(i)}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8 accepts with the consumer stalled
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
        check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_a", {16'd0, bus.a}, 32'h0001);
        check("t1_h", {16'd0, bus.h}, 32'h0008);
        check("t1_in_ready", {31'd0, bus.in_ready}, 32'd0);

        // hold FULL, then fire together with a new word
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h0F00 + 16'(i), 1'b0, 1'b0);
        drive(1'b1, 16'h00AA, 1'b1, 1'b0);
        check("t2_a", {16'd0, bus.a}, 32'h00AA);
        check("t2_fill_cnt", {29'd0, bus.fill_cnt}, 32'd1);
        check("t2_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // streaming with no stalls
        drive(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
            if (i == 23) begin
                check("t3_valid", {31'd0, bus.out_valid}, 32'd1);
                check("t3_a", {16'd0, bus.a}, 32'h0110);
                check("t3_h", {16'd0, bus.h}, 32'h0117);
            end
        end

        // flush alongside a 4th word
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1);
        check("t4_fill_cnt", {29'd0, bus.fill_cnt}, 32'd0);
        check("t4_out_valid", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        check("t4_a", {16'd0, bus.a}, 32'h0200);
        check("t4_h", {16'd0, bus.h}, 32'h0207);

        // asynchronous reset mid-bundle
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
        check("t5_fill_before", {29'd0, bus.fill_cnt}, 32'd5);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_fill_cnt", {29'd0, bus.fill_cnt}, 32'd0);
        check("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("t5_slot[%0d]", i), {16'd0, slot_out(i)}, 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // random traffic against the scoreboard
        n_fired = 0;
        for (int i = 0; i < 2000; i++)
            drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 2) == 1, ($urandom % 64) == 0);
        check("t6_bundles_seen", {31'd0, n_fired > 20}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
